// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one SPI byte engine between three requesters (sdcard, flash, lcd).
//   A requester owns the bus for a whole multi-byte transaction: chip-select is
//   raised, held across all bytes, then dropped for a quiet gap before the next
//   owner is picked round-robin.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid[2:0]        per-requester byte valid (0 sdcard, 1 flash, 2 lcd)
//   req_last[2:0]         presented byte closes that requester's transaction
//   tx_data[23:0]         requester i byte on [8i+7:8i]
//   lcd_c_d               lcd command/data bit, sampled with each lcd byte
//   grant[2:0]            one-hot owner while its transaction is open
//   byte_done[2:0]        1-cycle pulse to the owner when its byte completed
//   rx_data[7:0]          received byte, valid with byte_done
//   err[2:0]              1-cycle pulse to the owner on engine timeout
//   eng_start             1-cycle start pulse to the byte engine
//   eng_data[7:0]         byte to shift out
//   eng_cs[2:0]           100 sdcard, 010 flash, 001 lcd, 000 none
//   eng_c_d               lcd command/data bit to the engine
//   eng_done, eng_rx[7:0] engine byte-complete pulse and received byte

module spi_bus_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_last,
  input  logic [23:0] tx_data,
  input  logic        lcd_c_d,
  output logic [2:0]  grant,
  output logic [2:0]  byte_done,
  output logic [7:0]  rx_data,
  output logic [2:0]  err,
  output logic        eng_start,
  output logic [7:0]  eng_data,
  output logic [2:0]  eng_cs,
  output logic        eng_c_d,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx
);

  // One shared counter serves SETUP, WAIT and GAP, so it is sized for the largest.
  localparam int MAX_A = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int MAX_C = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] WAIT_END  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    owner;
  logic [2:0]    owner_oh;
  logic [7:0]    data_q;
  logic          cd_q;
  logic          last_q;
  logic          active;
  logic [7:0]    issue_byte;
  logic          issue_cd;

  // Pick the first valid requester after prev, wrapping sdcard -> flash -> lcd.
  function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] prev);
    logic [1:0] first, second, third;
    case (prev)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (valid[first])       rr_pick = first;
    else if (valid[second]) rr_pick = second;
    else                    rr_pick = third;
  endfunction

  assign owner_oh   = 3'b001 << owner;
  assign issue_byte = tx_data[{owner, 3'b000} +: 8];
  assign issue_cd   = (owner == 2'd2) ? lcd_c_d : 1'b0;

  // State, counter and datapath registers. owner doubles as the round-robin
  // pointer: it keeps the last granted index, and resets to lcd so sdcard wins
  // first. Byte, c/d and last flag are captured in ISSUE so the engine and the
  // WAIT exit decision see the values belonging to the byte actually started.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= 2'd2;
      data_q <= '0;
      cd_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && |req_valid) begin
        owner <= rr_pick(req_valid, owner);
      end
      if (state == ISSUE) begin
        data_q <= issue_byte;
        cd_q   <= issue_cd;
        last_q <= req_last[owner];
      end
    end
  end

  // Next-state and output decode. Chip-select and grant follow the state so
  // they cannot move while a byte is in flight, and they drop immediately on
  // reset. A completion arriving in the timeout cycle is honoured as a byte.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    active     = 1'b0;
    eng_start  = 1'b0;
    byte_done  = 3'b000;
    rx_data    = 8'h00;
    err        = 3'b000;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_next = SETUP;
          cnt_next   = '0;
        end
      end
      SETUP: begin
        active = 1'b1;
        if (cnt == SETUP_END) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ISSUE: begin
        active     = 1'b1;
        eng_start  = 1'b1;
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        active = 1'b1;
        if (eng_done) begin
          byte_done  = owner_oh;
          rx_data    = eng_rx;
          state_next = last_q ? GAP : HOLD;
          cnt_next   = '0;
        end else if (cnt == WAIT_END) begin
          err        = owner_oh;
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HOLD: begin
        active = 1'b1;
        if (req_valid[owner]) begin
          state_next = ISSUE;
        end
      end
      GAP: begin
        if (cnt == GAP_END) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign grant    = active ? owner_oh : 3'b000;
  assign eng_cs   = {grant[0], grant[1], grant[2]};
  assign eng_data = (state == ISSUE) ? issue_byte : data_q;
  assign eng_c_d  = (state == ISSUE) ? issue_cd : cd_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//   Scoreboard bench for spi_bus_arbiter: tests queue requester bytes and push
//   the engine-start / byte-done / err events they expect; a requester driver,
//   an engine model and a monitor run as separate processes.

module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [23:0] tx_data;
  logic        lcd_c_d;
  logic [2:0]  grant;
  logic [2:0]  byte_done;
  logic [7:0]  rx_data;
  logic [2:0]  err;
  logic        eng_start;
  logic [7:0]  eng_data;
  logic [2:0]  eng_cs;
  logic        eng_c_d;
  logic        eng_done;
  logic [7:0]  eng_rx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.CS_SETUP(2), .CS_GAP(4), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .tx_data(tx_data), .lcd_c_d(lcd_c_d), .grant(grant), .byte_done(byte_done),
    .rx_data(rx_data), .err(err), .eng_start(eng_start), .eng_data(eng_data),
    .eng_cs(eng_cs), .eng_c_d(eng_c_d), .eng_done(eng_done), .eng_rx(eng_rx)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       cd;
    int         delay;
  } item_t;

  typedef struct {
    int         kind;   // 0 start, 1 byte done, 2 err
    int         idx;
    logic [7:0] data;
    logic       cd;
  } exp_t;

  item_t      q0[$], q1[$], q2[$];
  exp_t       exp_q[$];
  logic [7:0] rsp_q[$];

  logic [2:0] rv, rl;
  logic [7:0] td [3];
  logic       cd_r;
  item_t      cur [3];
  bit         have [3];

  int eng_lat  = 2;
  bit eng_mute = 1'b0;

  assign req_valid = rv;
  assign req_last  = rl;
  assign tx_data   = {td[2], td[1], td[0]};
  assign lcd_c_d   = cd_r;

  function automatic logic [2:0] ohOf(input int i);
    return 3'(3'b001 << i);
  endfunction

  function automatic logic [2:0] csOf(input int i);
    return 3'(3'b100 >> i);
  endfunction

  function automatic bit reqBusy();
    return (q0.size() + q1.size() + q2.size() != 0) || have[0] || have[1] || have[2] || (rv != 3'b000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] d, input logic l, input logic c, input int dly);
    item_t it;
    it = '{data: d, last: l, cd: c, delay: dly};
    case (i)
      0:       q0.push_back(it);
      1:       q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  task automatic expectStart(input int i, input logic [7:0] d, input logic c);
    exp_q.push_back('{kind: 0, idx: i, data: d, cd: c});
  endtask

  task automatic expectDone(input int i, input logic [7:0] r);
    exp_q.push_back('{kind: 1, idx: i, data: r, cd: 1'b0});
    rsp_q.push_back(r);
  endtask

  task automatic expectErr(input int i);
    exp_q.push_back('{kind: 2, idx: i, data: 8'h00, cd: 1'b0});
  endtask

  task automatic popItem(input int i, output item_t it, output bit ok);
    ok = 1'b0;
    it = '{data: 8'h00, last: 1'b0, cd: 1'b0, delay: 0};
    case (i)
      0:       if (q0.size() > 0) begin it = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin it = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin it = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic flushQueue(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Requester driver: holds each byte until its byte_done (or err), then moves
  // to the next queued byte after its idle delay. Reset abandons everything.
  initial begin
    logic [2:0] bd, er;
    logic       rs;
    rv = 3'b000; rl = 3'b000; cd_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      td[i] = 8'h00; have[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      bd = byte_done; er = err; rs = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (rs) begin
          have[i] = 1'b0; rv[i] = 1'b0; rl[i] = 1'b0;
          flushQueue(i);
        end else begin
          if (rv[i] && (bd[i] || er[i])) begin
            rv[i] = 1'b0; rl[i] = 1'b0;
          end
          if (!rv[i]) begin
            if (!have[i]) popItem(i, cur[i], have[i]);
            if (have[i]) begin
              if (cur[i].delay > 0) begin
                cur[i].delay--;
              end else begin
                td[i] = cur[i].data; rl[i] = cur[i].last; rv[i] = 1'b1;
                if (i == 2) cd_r = cur[i].cd;
                have[i] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Engine model: answers each start after eng_lat cycles with the next
  // queued response, unless muted.
  initial begin
    logic [7:0] r;
    eng_done = 1'b0; eng_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_start && !eng_mute) begin
        r = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
        repeat (eng_lat) @(posedge clk);
        #1 eng_done = 1'b1; eng_rx = r;
        @(posedge clk);
        #1 eng_done = 1'b0; eng_rx = 8'h00;
      end
    end
  end

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d, required no event", kind);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("event_kind", kind, e.kind);
    case (kind)
      0: begin
        checkOutput("start_cs", 32'(eng_cs), 32'(csOf(e.idx)));
        checkOutput("start_grant", 32'(grant), 32'(ohOf(e.idx)));
        checkOutput("start_data", 32'(eng_data), 32'(e.data));
        checkOutput("start_c_d", 32'(eng_c_d), 32'(e.cd));
      end
      1: begin
        checkOutput("done_owner", 32'(byte_done), 32'(ohOf(e.idx)));
        checkOutput("done_rx_data", 32'(rx_data), 32'(e.data));
      end
      default: begin
        checkOutput("err_owner", 32'(err), 32'(ohOf(e.idx)));
        checkOutput("err_no_done", 32'(byte_done), 32'd0);
      end
    endcase
  endtask

  // Monitor: every DUT event is matched against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start) observe(0);
      if (byte_done != 3'b000) observe(1);
      if (err != 3'b000) observe(2);
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
      32'({grant, byte_done, rx_data, err, eng_start, eng_data, eng_cs, eng_c_d}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitStart(input string name, input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL %s: got no eng_start, required one within %0d cycles", name, budget);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int n = 0; n < budget && (exp_q.size() != 0 || reqBusy()); n++) @(negedge clk);
    checkOutput({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n, bad, dones;
    bit seen;
    rst = 1'b1;

    // Flash alone, three bytes, engine answers EF 40 18.
    applyReset();
    applyStimulus(1, 8'h9F, 1'b0, 1'b0, 0);
    applyStimulus(1, 8'h00, 1'b0, 1'b0, 0);
    applyStimulus(1, 8'h00, 1'b1, 1'b0, 0);
    expectStart(1, 8'h9F, 1'b0); expectDone(1, 8'hEF);
    expectStart(1, 8'h00, 1'b0); expectDone(1, 8'h40);
    expectStart(1, 8'h00, 1'b0); expectDone(1, 8'h18);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
      else if (eng_cs == 3'b010) n++;
    end
    checkOutput("flash_setup_cycles", 32'(n), 32'd2);
    bad = 0; dones = 0;
    for (int k = 0; k < 300 && dones < 3; k++) begin
      if (eng_cs != 3'b010) bad++;
      if (byte_done[1]) dones++;
      if (dones < 3) @(negedge clk);
    end
    checkOutput("flash_cs_held", 32'(bad), 32'd0);
    checkOutput("flash_done_count", 32'(dones), 32'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("flash_gap_cs", 32'({eng_cs, grant}), 32'd0);
    end
    waitDrain("flash", 100);

    // All three request at once; sdcard queues a second transaction.
    applyReset();
    applyStimulus(0, 8'h11, 1'b1, 1'b0, 0);
    applyStimulus(0, 8'h12, 1'b1, 1'b0, 0);
    applyStimulus(1, 8'h21, 1'b1, 1'b0, 0);
    applyStimulus(2, 8'h31, 1'b1, 1'b1, 0);
    expectStart(0, 8'h11, 1'b0); expectDone(0, 8'hA1);
    expectStart(1, 8'h21, 1'b0); expectDone(1, 8'hA2);
    expectStart(2, 8'h31, 1'b1); expectDone(2, 8'hA3);
    expectStart(0, 8'h12, 1'b0); expectDone(0, 8'hA4);
    waitDrain("round_robin", 300);

    // LCD command byte followed by data byte.
    applyReset();
    applyStimulus(2, 8'h2C, 1'b0, 1'b0, 0);
    applyStimulus(2, 8'h55, 1'b1, 1'b1, 0);
    expectStart(2, 8'h2C, 1'b0); expectDone(2, 8'hB1);
    expectStart(2, 8'h55, 1'b1); expectDone(2, 8'hB2);
    waitDrain("lcd", 100);

    // Engine never answers: err after exactly 1000 cycles.
    applyReset();
    eng_mute = 1'b1;
    applyStimulus(0, 8'h77, 1'b1, 1'b0, 0);
    expectStart(0, 8'h77, 1'b0); expectErr(0);
    waitStart("timeout_start", 50, seen);
    n = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      n++;
      if (err != 3'b000 || byte_done != 3'b000) break;
    end
    checkOutput("timeout_latency", 32'(n), 32'd1000);
    @(negedge clk);
    checkOutput("timeout_cs_off", 32'(eng_cs), 32'd0);
    waitDrain("timeout", 50);
    eng_mute = 1'b0;

    // sdcard pauses 50 cycles mid-transaction while flash waits.
    applyReset();
    applyStimulus(0, 8'h01, 1'b0, 1'b0, 0);
    applyStimulus(0, 8'h02, 1'b1, 1'b0, 50);
    applyStimulus(1, 8'h33, 1'b1, 1'b0, 3);
    expectStart(0, 8'h01, 1'b0); expectDone(0, 8'hC1);
    expectStart(0, 8'h02, 1'b0); expectDone(0, 8'hC2);
    expectStart(1, 8'h33, 1'b0); expectDone(1, 8'hC3);
    waitStart("hold_start", 50, seen);
    bad = 0; dones = 0;
    for (int k = 0; k < 400 && dones < 2; k++) begin
      if (eng_cs != 3'b100 || grant != 3'b001) bad++;
      if (byte_done[0]) dones++;
      if (dones < 2) @(negedge clk);
    end
    checkOutput("hold_cs_owner", 32'(bad), 32'd0);
    checkOutput("hold_sd_done", 32'(dones), 32'd2);
    waitDrain("hold", 100);

    // Reset while waiting on the engine; its late answer must be ignored.
    applyReset();
    eng_lat = 6;
    rsp_q.push_back(8'h99);
    applyStimulus(0, 8'h5A, 1'b1, 1'b0, 0);
    expectStart(0, 8'h5A, 1'b0);
    waitStart("rst_start", 50, seen);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_outputs",
      32'({grant, byte_done, rx_data, err, eng_start, eng_data, eng_cs, eng_c_d}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (byte_done != 3'b000 || err != 3'b000 || eng_cs != 3'b000 || grant != 3'b000) bad++;
    end
    checkOutput("late_done_ignored", 32'(bad), 32'd0);
    eng_lat = 2;
    waitDrain("rst", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 The block SHALL use parameter CS_SETUP, default 2, giving the number of clk cycles from chip-select assertion to the first engine start.
REQ-002 The block SHALL use parameter CS_GAP, default 4, giving the minimum number of clk cycles with all chip-selects deasserted between two transactions.
REQ-003 The block SHALL use parameter TIMEOUT, default 1000, giving the maximum number of clk cycles in WAIT before the transaction is aborted.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, 3 bits: per-requester byte valid; bit0 = sdcard, bit1 = flash, bit2 = lcd.
REQ-007 The block SHALL have port req_last, input, 3 bits: the presented byte is the final byte of that requester's transaction.
REQ-008 The block SHALL have port tx_data, input, 24 bits: requester i byte on [8i+7:8i].
REQ-009 The block SHALL have port lcd_c_d, input, 1 bit: LCD command/data bit, sampled with each lcd byte.
REQ-010 The block SHALL have port grant, output, 3 bits: one-hot owner of the bus while its transaction is open; 0 otherwise.
REQ-011 The block SHALL have port byte_done, output, 3 bits: 1-cycle pulse to the owner when its byte has completed.
REQ-012 The block SHALL have port rx_data, output, 8 bits: received byte, valid in the cycle byte_done pulses.
REQ-013 The block SHALL have port err, output, 3 bits: 1-cycle pulse to the owner on timeout abort.
REQ-014 The block SHALL have port eng_start, output, 1 bit: 1-cycle start pulse to the SPI byte engine.
REQ-015 The block SHALL have port eng_data, output, 8 bits: byte to shift out.
REQ-016 The block SHALL have port eng_cs, output, 3 bits: 3'b100 = sdcard, 3'b010 = flash, 3'b001 = lcd, 3'b000 = none.
REQ-017 The block SHALL have port eng_c_d, output, 1 bit: LCD command/data bit to the engine.
REQ-018 The block SHALL have port eng_done, input, 1 bit: engine byte-complete pulse.
REQ-019 The block SHALL have port eng_rx, input, 8 bits: engine received byte, valid when eng_done pulses.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ISSUE, WAIT, HOLD and GAP.
REQ-021 In IDLE with any req_valid bit set, the block SHALL pick a requester round-robin starting after the last granted one (sdcard first after reset), then set grant and eng_cs on the next clk and enter SETUP.
REQ-022 In SETUP, the block SHALL count CS_SETUP cycles and then enter ISSUE.
REQ-023 In ISSUE, the block SHALL pulse eng_start for exactly 1 cycle and, in that same cycle, latch eng_data from the owner's tx_data byte and eng_c_d from lcd_c_d (0 for non-lcd owners), then enter WAIT.
REQ-024 In WAIT on eng_done, the block SHALL pulse byte_done[owner] with rx_data = eng_rx, then enter GAP if the latched req_last was set, else HOLD.
REQ-025 In HOLD, the block SHALL keep eng_cs asserted and enter ISSUE on the first cycle req_valid[owner] is 1; it SHALL wait indefinitely, and the requests of other requesters SHALL be ignored.
REQ-026 In GAP, the block SHALL hold eng_cs = 0 and grant = 0 for CS_GAP cycles, then return to IDLE.
REQ-027 A requester SHALL hold req_valid, tx_data and req_last stable until byte_done; byte_done is the acceptance handshake.
REQ-028 If the WAIT cycle count reaches TIMEOUT, the block SHALL pulse err[owner], not pulse byte_done, and enter GAP.
REQ-029 eng_done SHALL be ignored outside WAIT.
REQ-030 Simultaneous requests SHALL be served strictly round-robin, so no requester waits for more than two foreign transactions.
REQ-031 eng_cs SHALL be one-hot or zero at all times, and SHALL never change between ISSUE and the matching eng_done.

Reset
REQ-032 While rst is high, all outputs SHALL be 0, the state SHALL be IDLE, the round-robin pointer SHALL be at lcd (so sdcard wins next), and all counters SHALL be cleared.
REQ-033 rst asserted mid-transaction SHALL deassert eng_cs on the next clk edge with no byte_done or err pulse.

Verification
REQ-034 The bench SHALL drive flash alone with 3 bytes 0x9F, 0x00, 0x00 (last on the third) and an engine model returning 0xEF, 0x40, 0x18; it SHALL check eng_cs = 010 throughout, 3 byte_done pulses with those rx_data values, and eng_cs = 000 for 4 cycles afterwards.
REQ-035 The bench SHALL raise all three req_valid bits together with single-byte transactions and check grant order sdcard, flash, lcd, sdcard.
REQ-036 The bench SHALL raise lcd byte 0x2C with lcd_c_d = 0 followed by byte 0x55 with lcd_c_d = 1, and check eng_c_d = 0 then 1 and eng_cs = 001.
REQ-037 The bench SHALL run with the engine never returning eng_done, and check an err pulse 1000 cycles after eng_start, no byte_done, and eng_cs = 000.
REQ-038 The bench SHALL drop req_valid between bytes of a sdcard transaction for 50 cycles while flash requests, and check that eng_cs stays 100 and flash is not granted until sdcard's last byte.
REQ-039 The bench SHALL assert rst during WAIT and check all outputs = 0 on the next cycle, and that a late eng_done is ignored.
